seg2bin_rx: RTL and testbench
=============================

// Module: seg2bin_rx
// PURPOSE
//   Receive side of the 7-segment display path. Deserialises a 14-bit segment frame,
//   sent as tens pattern then ones pattern, MSB (segment a) first.
//   Decodes each 7-bit abcdefg pattern back to a BCD digit, then converts the BCD pair to binary.
//   Delivers the result on a valid/ready output. Used to close the loop on the bin-to-BCD/display encoder.
// PARAMETERS
//   BIN_W    7    width of bin_out; must be >= 7 to hold 99
//   CNT_W    8    width of frame_cnt
// PORTS
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   s_bit        in   1      serial segment bit
//   s_valid      in   1      s_bit qualifier; bit accepted when s_valid && s_ready
//   s_sof        in   1      start of frame, coincident with first bit (s_valid must be high)
//   s_ready      out  1      high in IDLE and SHIFT only
//   bcd_out      out  8      {tens,ones}; invalid digit reported as 4'hF
//   bin_out      out  BIN_W  tens*10+ones; 0 when err_seg
//   err_seg      out  1      some pattern in frame was not one of the 10 legal codes
//   out_valid    out  1      result valid; held until out_ready
//   out_ready    in   1      consumer accept
//   frame_cnt    out  CNT_W  count of delivered frames, wraps max->0
// BEHAVIOUR
//   Reset (any time, incl. mid-frame): state=IDLE, shift reg/bit count cleared.
//     bcd_out=0, bin_out=0, err_seg=0, out_valid=0, frame_cnt=0, s_ready=1.
//   Legal codes (a=MSB): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B.
//   FSM states: IDLE, SHIFT, DECODE, CONVERT, HOLD.
//   IDLE: accepted bit with s_sof -> load bit, cnt=1, go SHIFT. Accepted bit without s_sof is ignored.
//   SHIFT: each accepted bit shifts in at LSB and increments cnt.
//     - 14th bit accepted -> DECODE.
//     - s_sof on an accepted bit -> restart: shift reg = that bit, cnt=1. Partial frame dropped, no output.
//     - s_valid low -> hold state; there is no inter-bit timeout.
//   DECODE (1 cycle): register tens/ones digits and per-digit invalid flags -> CONVERT.
//   CONVERT (1 cycle): bin = (tens<<3)+(tens<<1)+ones, zero-extended to BIN_W.
//     Any invalid flag forces bin=0 and err_seg=1.
//     Update bcd_out, bin_out, err_seg; out_valid<=1; frame_cnt++; go HOLD.
//   HOLD: outputs stable, s_ready=0, s_bit ignored.
//     out_valid && out_ready -> out_valid<=0, IDLE on next edge.
//   Latency: 14th bit sampled at edge E; out_valid high after edge E+2. Frame-to-frame minimum 17 cycles.
//   bcd_out/bin_out/err_seg keep the last frame's values after the handshake, until the next CONVERT.
//   out_ready high before out_valid has no effect.
// CONFIGURATION
//   SEG_ACTIVE_LOW_EN defined: incoming bits inverted before shift (common-anode panel).
//     Legal codes then arrive as bitwise complements of the table above.
//   SEG_ACTIVE_LOW_EN undefined: active-high segments, bits used as received.
//   No other behaviour changes.
// TESTING
//   1. sof + 0110000,1111001 contiguous -> bcd_out=8'h13, bin_out=13, err_seg=0.
//      out_valid 2 edges after bit 14; frame_cnt=1.
//   2. Frames 7E7E then 7B7B -> bin_out 0 then 99; bcd_out 8'h00 then 8'h99; frame_cnt=2.
//   3. Tens=0000000, ones=1111001 -> err_seg=1, bcd_out=8'hF3, bin_out=0; out_valid still asserted.
//   4. sof, 5 bits, then sof + full "42" frame (0110011,1101101) -> exactly one out_valid.
//      Result bin_out=42; no output for the partial frame.
//   5. out_ready low 5 cycles with s_valid toggling -> out_valid, outputs and s_ready=0 held; bits ignored.
//      Raise out_ready -> out_valid drops next edge, s_ready=1.
//   6. rst pulse after bit 9 of a frame -> all outputs 0 immediately (async), IDLE.
//      Next full "07" frame -> bin_out=7.
//      With SEG_ACTIVE_LOW_EN, repeat test 1 with complemented bits -> bin_out=13.

Source files
------------

// File: rtl/seg2bin_rx.sv
// seg2bin_rx: receive a 14-bit serial 7-segment frame (tens then ones, segment a first),
//   decode both patterns to BCD and convert the pair to binary on a valid/ready output.
//   Ports: clk, rst (async, active-high); s_bit/s_valid/s_sof/s_ready serial input;
//   bcd_out {tens,ones} (4'hF per bad digit), bin_out, err_seg, out_valid/out_ready
//   result handshake; frame_cnt delivered-frame counter.
//   Optional: SEG_ACTIVE_LOW_EN inverts incoming bits for common-anode panels.
module seg2bin_rx #(
  parameter int BIN_W = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_bit,
  input  logic             s_valid,
  input  logic             s_sof,
  output logic             s_ready,
  output logic [7:0]       bcd_out,
  output logic [BIN_W-1:0] bin_out,
  output logic             err_seg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_cnt
);
  typedef enum logic [2:0] {IDLE, SHIFT, DECODE, CONVERT, HOLD} state_t;
  state_t           state_q, state_d;
  logic [13:0]      sr_q, sr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic             tinv_q, tinv_d, oinv_q, oinv_d;
  logic [7:0]       bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             err_q, err_d, ov_q, ov_d;
  logic [CNT_W-1:0] fc_q, fc_d;
  logic             b, acc;
  logic [4:0]       td, od;
  logic [6:0]       bin7;
  // {invalid, digit}; an unknown pattern yields 5'h1F so the digit reads 4'hF
  function automatic logic [4:0] dec(input logic [6:0] p);
    case (p)
      7'h7E:   dec = 5'd0;
      7'h30:   dec = 5'd1;
      7'h6D:   dec = 5'd2;
      7'h79:   dec = 5'd3;
      7'h33:   dec = 5'd4;
      7'h5B:   dec = 5'd5;
      7'h5F:   dec = 5'd6;
      7'h70:   dec = 5'd7;
      7'h7F:   dec = 5'd8;
      7'h7B:   dec = 5'd9;
      default: dec = 5'h1F;
    endcase
  endfunction
`ifdef SEG_ACTIVE_LOW_EN
  assign b = ~s_bit;
`else
  assign b = s_bit;
`endif
  assign s_ready   = state_q == IDLE || state_q == SHIFT;
  assign acc       = s_valid && s_ready;
  assign td        = dec(sr_q[13:7]);
  assign od        = dec(sr_q[6:0]);
  // tens*10 as tens*8 + tens*2; max 99 fits in 7 bits
  assign bin7      = {tens_q, 3'b0} + {2'b0, tens_q, 1'b0} + {3'b0, ones_q};
  assign bcd_out   = bcd_q;
  assign bin_out   = bin_q;
  assign err_seg   = err_q;
  assign out_valid = ov_q;
  assign frame_cnt = fc_q;
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    tinv_d  = tinv_q;
    oinv_d  = oinv_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    err_d   = err_q;
    ov_d    = ov_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE: if (acc && s_sof) begin
        sr_d    = {13'b0, b};
        cnt_d   = 4'd1;
        state_d = SHIFT;
      end
      SHIFT: if (acc) begin
        sr_d    = s_sof ? {13'b0, b} : {sr_q[12:0], b};
        cnt_d   = s_sof ? 4'd1 : cnt_q + 4'd1;
        state_d = (!s_sof && cnt_q == 4'd13) ? DECODE : SHIFT;
      end
      DECODE: begin
        tens_d  = td[3:0];
        ones_d  = od[3:0];
        tinv_d  = td[4];
        oinv_d  = od[4];
        state_d = CONVERT;
      end
      CONVERT: begin
        bcd_d   = {tens_q, ones_q};
        err_d   = tinv_q | oinv_q;
        bin_d   = err_d ? '0 : BIN_W'(bin7);
        ov_d    = 1'b1;
        fc_d    = fc_q + 1'b1;
        state_d = HOLD;
      end
      HOLD: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      tinv_q  <= 1'b0;
      oinv_q  <= 1'b0;
      bcd_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      tinv_q  <= tinv_d;
      oinv_q  <= oinv_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      fc_q    <= fc_d;
    end
  end
endmodule

// File: tb/tb_seg2bin_rx.sv
// tb_seg2bin_rx: directed frames against a per-cycle bit-queue model of seg2bin_rx.
module tb_seg2bin_rx;
  logic       clk = 0, rst = 1, s_bit = 0, s_valid = 0, s_sof = 0, out_ready = 0;
  logic       s_ready, err_seg, out_valid;
  logic [7:0] bcd_out, frame_cnt;
  logic [6:0] bin_out;
`ifdef SEG_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  seg2bin_rx dut (
    .clk(clk), .rst(rst), .s_bit(s_bit), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .bcd_out(bcd_out), .bin_out(bin_out), .err_seg(err_seg),
    .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask
  logic [6:0] codes [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  function automatic int dig(input logic [6:0] p);
    dig = -1;
    for (int i = 0; i < 10; i++) if (codes[i] == p) dig = i;
  endfunction
  // Model: collect accepted bits into a queue; a 14-bit frame becomes visible two edges later
  logic       mq [$];
  int         m_pipe;
  logic       m_ov, m_ready, m_err, r_err;
  logic [7:0] m_bcd, m_fc, r_bcd;
  int         m_bin, r_bin;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mq.delete();
      m_pipe = 0; m_ov = 0; m_ready = 1; m_err = 0; m_bcd = 0; m_bin = 0; m_fc = 0;
    end
    check("ov", out_valid, m_ov);
    check("rdy", s_ready, m_ready);
    check("bcd", bcd_out, m_bcd);
    check("bin", bin_out, m_bin);
    check("err", err_seg, m_err);
    check("fc", frame_cnt, m_fc);
    if (!rst) begin
      if (m_pipe > 0) begin
        m_pipe--;
        if (m_pipe == 0) begin
          m_bcd = r_bcd; m_bin = r_bin; m_err = r_err; m_ov = 1; m_fc++;
        end
      end else if (m_ov && out_ready) begin
        m_ov = 0; m_ready = 1;
      end else if (m_ready && s_valid) begin
        if (s_sof) begin
          mq.delete();
          mq.push_back(s_bit ^ INV);
        end else if (mq.size() > 0) mq.push_back(s_bit ^ INV);
        if (mq.size() == 14) begin
          logic [13:0] f;
          int t, o;
          for (int i = 0; i < 14; i++) f[13-i] = mq[i];
          t = dig(f[13:7]);
          o = dig(f[6:0]);
          r_err = t < 0 || o < 0;
          r_bcd = {t < 0 ? 4'hF : 4'(t), o < 0 ? 4'hF : 4'(o)};
          r_bin = r_err ? 0 : t * 10 + o;
          mq.delete();
          m_ready = 0;
          m_pipe = 2;
        end
      end
    end
  end
  task automatic drive(input logic b, input logic sof);
    s_valid = 1; s_bit = b ^ INV; s_sof = sof;
    @(posedge clk); #1;
    s_valid = 0; s_sof = 0;
  endtask
  task automatic frame(input logic [6:0] t, input logic [6:0] o);
    logic [13:0] f;
    f = {t, o};
    for (int i = 13; i >= 0; i--) drive(f[i], i == 13);
  endtask
  task automatic take();
    int k;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("take_timeout", out_valid, 1);
  endtask
  task automatic ack();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  initial begin
    logic [13:0] f;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", s_ready, 1);
    check("rst_ov", out_valid, 0);
    check("rst_fc", frame_cnt, 0);
    rst = 0;
    // 1: "13" with exact latency
    frame(7'h30, 7'h79);
    check("t1_lat0", out_valid, 0);
    @(posedge clk); #1;
    check("t1_lat1", out_valid, 0);
    @(posedge clk); #1;
    check("t1_lat2", out_valid, 1);
    check("t1_bcd", bcd_out, 8'h13);
    check("t1_bin", bin_out, 13);
    check("t1_err", err_seg, 0);
    check("t1_fc", frame_cnt, 1);
    ack();
    // 2: 00 then 99, second with out_ready already high
    frame(7'h7E, 7'h7E);
    take();
    check("t2_bin0", bin_out, 0);
    check("t2_bcd0", bcd_out, 8'h00);
    ack();
    out_ready = 1;
    frame(7'h7B, 7'h7B);
    take();
    check("t2_bin99", bin_out, 99);
    check("t2_bcd99", bcd_out, 8'h99);
    check("t2_fc", frame_cnt, 3);
    @(posedge clk); #1;
    check("t2_drop", out_valid, 0);
    out_ready = 0;
    // 3: illegal tens pattern
    frame(7'h00, 7'h79);
    take();
    check("t3_err", err_seg, 1);
    check("t3_bcd", bcd_out, 8'hF3);
    check("t3_bin", bin_out, 0);
    ack();
    // 4: partial frame restarted by sof
    f = {7'h7F, 7'h7F};
    for (int i = 13; i >= 9; i--) drive(f[i], i == 13);
    frame(7'h33, 7'h6D);
    take();
    check("t4_bin", bin_out, 42);
    check("t4_bcd", bcd_out, 8'h42);
    check("t4_fc", frame_cnt, 5);
    ack();
    // 5: hold under back-pressure with input activity
    frame(7'h5B, 7'h5F);
    take();
    for (int k = 0; k < 5; k++) begin
      s_valid = k[0]; s_sof = k[0]; s_bit = 1'($urandom);
      @(posedge clk); #1;
      check("t5_ov", out_valid, 1);
      check("t5_rdy", s_ready, 0);
      check("t5_bin", bin_out, 56);
    end
    s_valid = 0; s_sof = 0; out_ready = 1;
    @(posedge clk); #1;
    check("t5_drop", out_valid, 0);
    check("t5_rdy1", s_ready, 1);
    out_ready = 0;
    // 6: async reset mid-frame, then "07"
    f = {7'h7E, 7'h70};
    for (int i = 13; i >= 5; i--) drive(f[i], i == 13);
    rst = 1;
    #1;
    check("t6_bcd", bcd_out, 0);
    check("t6_bin", bin_out, 0);
    check("t6_err", err_seg, 0);
    check("t6_ov", out_valid, 0);
    check("t6_fc", frame_cnt, 0);
    check("t6_rdy", s_ready, 1);
    @(posedge clk); #1;
    rst = 0;
    frame(7'h7E, 7'h70);
    take();
    check("t6_bin7", bin_out, 7);
    check("t6_fc1", frame_cnt, 1);
    ack();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
